// File: rtl/pca_register_write_sequencer.sv
// pca_register_write_sequencer: sole writer of the register store. Merges the
// default sweep, single I2C writes and ALL_LED broadcasts into one write/cycle.
// Ports: clk_i, rst_ni (sync, active low), soft_rst_ni (active low);
//   i2c_register_id_i/_value_i, i2c_write_enable_i (level) from the I2C target;
//   write_register_id_o/_value_o, write_enable_o to the store;
//   busy_o, init_done_o, drop_o status.
// Option: define PCA_ALL_LED_BROADCAST_EN to fan ALL_LED writes (70..73)
//   out to all 16 per-channel LED registers.
module pca_register_write_sequencer #(
   parameter int NUM_REGS     = 76,
   parameter int ALL_LED_BASE = 70,
   parameter int LED_BASE     = 6,
   parameter int NUM_CH       = 16
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic [7:0] i2c_register_id_i,
   input  logic [7:0] i2c_register_value_i,
   input  logic       i2c_write_enable_i,
   input  logic       soft_rst_ni,
   output logic [7:0] write_register_id_o,
   output logic [7:0] write_register_value_o,
   output logic       write_enable_o,
   output logic       busy_o,
   output logic       init_done_o,
   output logic       drop_o
);

   localparam logic [7:0] NumRegs = 8'(NUM_REGS);
   localparam logic [7:0] LastIdx = 8'(NUM_REGS - 1);
   localparam logic [7:0] AllBase = 8'(ALL_LED_BASE);
   localparam logic [7:0] LedBase = 8'(LED_BASE);
   localparam logic [7:0] LedEnd  = 8'(LED_BASE + 4 * NUM_CH);
`ifdef PCA_ALL_LED_BROADCAST_EN
   localparam logic [7:0] LastCh  = 8'(NUM_CH - 1);
`endif

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SWEEP = 2'd1
`ifdef PCA_ALL_LED_BROADCAST_EN
      ,BCAST = 2'd2
`endif
   } state_e;

   // Power-on contents of the store.
   function automatic logic [7:0] dflt(input logic [7:0] idx);
      logic [1:0] rel;
      rel  = idx[1:0] - LedBase[1:0];
      dflt = 8'h00;
      case (idx)
         8'd0: dflt = 8'h11;
         8'd1: dflt = 8'h04;
         8'd2: dflt = 8'hE2;
         8'd3: dflt = 8'hE4;
         8'd4: dflt = 8'hE8;
         8'd5: dflt = 8'hE0;
         default: begin
            // OFF_H of every channel and of ALL_LED start with full-off set
            if (idx >= LedBase && idx < LedEnd && rel == 2'd3)
               dflt = 8'h10;
            else if (idx == AllBase + 8'd3)
               dflt = 8'h10;
            else if (idx == AllBase + 8'd4)
               dflt = 8'h1E;
         end
      endcase
   endfunction

   state_e     state_q, state_d;
   logic [7:0] idx_q, idx_d;
   logic       fin_q, fin_d;
   logic       prev_q;
   logic       pend_v_q, pend_v_d;
   logic [7:0] pend_id_q, pend_id_d;
   logic [7:0] pend_val_q, pend_val_d;
   logic       we_q, we_d;
   logic [7:0] id_q, id_d;
   logic [7:0] val_q, val_d;
   logic       busy_q, busy_d;
   logic       done_q, done_d;
   logic       drop_q, drop_d;
`ifdef PCA_ALL_LED_BROADCAST_EN
   logic [1:0] boff_q, boff_d;
   logic [7:0] bval_q, bval_d;
`endif

   logic       req;
   logic       srv_v;
   logic [7:0] srv_id;
   logic [7:0] srv_val;

   always_comb begin
      req        = i2c_write_enable_i & ~prev_q;
      state_d    = state_q;
      idx_d      = idx_q;
      fin_d      = 1'b0;
      pend_v_d   = pend_v_q;
      pend_id_d  = pend_id_q;
      pend_val_d = pend_val_q;
      we_d       = 1'b0;
      id_d       = id_q;
      val_d      = val_q;
      busy_d     = 1'b0;
      // init_done rises one cycle after the last sweep strobe
      done_d     = done_q | fin_q;
      drop_d     = 1'b0;
      srv_v      = 1'b0;
      srv_id     = pend_id_q;
      srv_val    = pend_val_q;
`ifdef PCA_ALL_LED_BROADCAST_EN
      boff_d     = boff_q;
      bval_d     = bval_q;
`endif
      if (!soft_rst_ni) begin
         state_d  = SWEEP;
         idx_d    = '0;
         pend_v_d = 1'b0;
         busy_d   = 1'b1;
         drop_d   = req;
      end else begin
         if (req) begin
            if (pend_v_q) begin
               drop_d = 1'b1;
            end else if (state_q != IDLE) begin
               pend_v_d   = 1'b1;
               pend_id_d  = i2c_register_id_i;
               pend_val_d = i2c_register_value_i;
            end else begin
               srv_v   = 1'b1;
               srv_id  = i2c_register_id_i;
               srv_val = i2c_register_value_i;
            end
         end
         case (state_q)
            IDLE: begin
               if (pend_v_q) begin
                  srv_v    = 1'b1;
                  pend_v_d = 1'b0;
               end
            end
            SWEEP: begin
               we_d   = 1'b1;
               id_d   = idx_q;
               val_d  = dflt(idx_q);
               busy_d = 1'b1;
               if (idx_q == LastIdx) begin
                  state_d = IDLE;
                  idx_d   = '0;
                  fin_d   = 1'b1;
               end else begin
                  idx_d = idx_q + 8'd1;
               end
            end
`ifdef PCA_ALL_LED_BROADCAST_EN
            BCAST: begin
               we_d   = 1'b1;
               id_d   = LedBase + {idx_q[5:0], 2'b00} + {6'd0, boff_q};
               val_d  = bval_q;
               busy_d = 1'b1;
               if (idx_q == LastCh) begin
                  state_d = IDLE;
                  idx_d   = '0;
               end else begin
                  idx_d = idx_q + 8'd1;
               end
            end
`endif
            default: state_d = IDLE;
         endcase
         if (srv_v) begin
            if (srv_id < NumRegs) begin
               we_d  = 1'b1;
               id_d  = srv_id;
               val_d = srv_val;
`ifdef PCA_ALL_LED_BROADCAST_EN
               // ALL_LED byte lands as-is, then fans out per channel
               if (srv_id >= AllBase && srv_id <= AllBase + 8'd3) begin
                  state_d = BCAST;
                  idx_d   = '0;
                  boff_d  = srv_id[1:0] - AllBase[1:0];
                  bval_d  = srv_val;
                  busy_d  = 1'b1;
               end
`endif
            end else begin
               drop_d = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q    <= SWEEP;
         idx_q      <= '0;
         fin_q      <= 1'b0;
         prev_q     <= 1'b0;
         pend_v_q   <= 1'b0;
         pend_id_q  <= '0;
         pend_val_q <= '0;
         we_q       <= 1'b0;
         id_q       <= '0;
         val_q      <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         drop_q     <= 1'b0;
`ifdef PCA_ALL_LED_BROADCAST_EN
         boff_q     <= '0;
         bval_q     <= '0;
`endif
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         fin_q      <= fin_d;
         prev_q     <= i2c_write_enable_i;
         pend_v_q   <= pend_v_d;
         pend_id_q  <= pend_id_d;
         pend_val_q <= pend_val_d;
         we_q       <= we_d;
         id_q       <= id_d;
         val_q      <= val_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         drop_q     <= drop_d;
`ifdef PCA_ALL_LED_BROADCAST_EN
         boff_q     <= boff_d;
         bval_q     <= bval_d;
`endif
      end
   end

   assign write_enable_o         = we_q;
   assign write_register_id_o    = id_q;
   assign write_register_value_o = val_q;
   assign busy_o                 = busy_q;
   assign init_done_o            = done_q;
   assign drop_o                 = drop_q;

endmodule

// File: tb/tb_pca_register_write_sequencer.sv
// Bench for pca_register_write_sequencer: queue-based reference model
// compared every cycle, plus directed literal checks and random traffic.
`timescale 1ns/1ps
module tb_pca_register_write_sequencer;

   logic       clk = 1'b0;
   logic       rst_n, soft_n, en;
   logic [7:0] id_in, val_in;
   logic [7:0] write_register_id_o, write_register_value_o;
   logic       write_enable_o, busy_o, init_done_o, drop_o;

   always #5 clk = ~clk;

   pca_register_write_sequencer dut (
      .clk_i                  (clk),
      .rst_ni                 (rst_n),
      .i2c_register_id_i      (id_in),
      .i2c_register_value_i   (val_in),
      .i2c_write_enable_i     (en),
      .soft_rst_ni            (soft_n),
      .write_register_id_o    (write_register_id_o),
      .write_register_value_o (write_register_value_o),
      .write_enable_o         (write_enable_o),
      .busy_o                 (busy_o),
      .init_done_o            (init_done_o),
      .drop_o                 (drop_o)
   );

   int checks = 0;
   int failures = 0;

   typedef struct packed {
      logic [7:0] id;
      logic [7:0] val;
      logic       last;
   } item_t;
   typedef struct packed {
      logic [7:0] id;
      logic [7:0] val;
   } wr_t;

   // Reference model: outstanding store writes as a plain work list.
   item_t      work[$];
   bit         m_prev, m_pend_v, m_fin;
   logic [7:0] m_pend_id, m_pend_val;
   logic       e_we, e_busy, e_done, e_drop;
   logic [7:0] e_id, e_val;
   bit         e_idval;

   wr_t wlog[$];
   int  drops, busy_cnt;

   function automatic logic [7:0] default_of(int i);
      case (i)
         0: return 8'h11;
         1: return 8'h04;
         2: return 8'hE2;
         3: return 8'hE4;
         4: return 8'hE8;
         5: return 8'hE0;
         default: ;
      endcase
      if (i >= 6 && i < 70 && (i - 6) % 4 == 3) return 8'h10;
      if (i == 73) return 8'h10;
      if (i == 74) return 8'h1E;
      return 8'h00;
   endfunction

   task automatic load_sweep();
      for (int i = 0; i < 76; i++)
         work.push_back('{id: 8'(i), val: default_of(i), last: (i == 75)});
   endtask

   task automatic emit(input logic [7:0] id, input logic [7:0] val);
      e_we    = 1'b1;
      e_id    = id;
      e_val   = val;
      e_idval = 1'b1;
   endtask

   task automatic serve(input logic [7:0] id, input logic [7:0] val);
      if (id < 76) begin
         emit(id, val);
`ifdef PCA_ALL_LED_BROADCAST_EN
         if (id >= 70 && id <= 73) begin
            for (int ch = 0; ch < 16; ch++)
               work.push_back('{id: 8'(6 + 4 * ch + (int'(id) - 70)),
                                val: val, last: 1'b0});
            e_busy = 1'b1;
         end
`endif
      end else begin
         e_drop = 1'b1;
      end
   endtask

   task automatic model_edge();
      bit    req, active;
      item_t it;
      if (!rst_n) begin
         work.delete();
         load_sweep();
         m_pend_v = 0; m_prev = 0; m_fin = 0;
         e_we = 0; e_busy = 0; e_done = 0; e_drop = 0;
         e_id = 0; e_val = 0; e_idval = 1;
         return;
      end
      req    = en && !m_prev;
      m_prev = en;
      e_we = 0; e_drop = 0; e_busy = 0; e_idval = 0;
      e_done = e_done | m_fin;
      m_fin  = 0;
      if (!soft_n) begin
         work.delete();
         load_sweep();
         m_pend_v = 0;
         e_drop   = req;
         e_busy   = 1;
         return;
      end
      active = work.size() != 0;
      if (req && m_pend_v) begin
         e_drop = 1;
      end else if (req && active) begin
         m_pend_v   = 1;
         m_pend_id  = id_in;
         m_pend_val = val_in;
      end
      if (active) begin
         it = work.pop_front();
         emit(it.id, it.val);
         e_busy = 1;
         m_fin  = it.last;
      end else if (m_pend_v) begin
         m_pend_v = 0;
         serve(m_pend_id, m_pend_val);
      end else if (req) begin
         serve(id_in, val_in);
      end
   endtask

   task automatic chk(input string name, input logic [7:0] act,
                      input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%02h expected 0x%02h at %0t",
                  name, act, exp, $time);
      end
   endtask

   task automatic check_outputs();
      chk("write_enable", 8'(write_enable_o), 8'(e_we));
      chk("busy", 8'(busy_o), 8'(e_busy));
      chk("init_done", 8'(init_done_o), 8'(e_done));
      chk("drop", 8'(drop_o), 8'(e_drop));
      if (e_idval) begin
         chk("write_id", write_register_id_o, e_id);
         chk("write_value", write_register_value_o, e_val);
      end
      if (write_enable_o === 1'b1)
         wlog.push_back({write_register_id_o, write_register_value_o});
      if (drop_o === 1'b1) drops++;
      if (busy_o === 1'b1) busy_cnt++;
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      @(negedge clk);
      check_outputs();
   endtask

   initial begin
      int r, bad;
      rst_n = 0; soft_n = 1; en = 0; id_in = 0; val_in = 0;
      @(negedge clk);
      tick(); tick();
      chk("reset_we", 8'(write_enable_o), 8'd0);
      chk("reset_busy", 8'(busy_o), 8'd0);

      // power-on sweep
      rst_n = 1;
      wlog.delete();
      repeat (76) tick();
      chk("sweep_count", 8'(wlog.size()), 8'd76);
      if (wlog.size() >= 76) begin
         bad = 0;
         for (int i = 0; i < 76; i++)
            if (wlog[i].id != 8'(i)) bad++;
         chk("sweep_order", 8'(bad), 8'd0);
         chk("sweep_id0", wlog[0].val, 8'h11);
         chk("sweep_id9", wlog[9].val, 8'h10);
         chk("sweep_id74", wlog[74].val, 8'h1E);
         chk("sweep_id7", wlog[7].val, 8'h00);
      end
      chk("init_done_at_last", 8'(init_done_o), 8'd0);
      tick();
      chk("init_done_after", 8'(init_done_o), 8'd1);
      chk("busy_after_sweep", 8'(busy_o), 8'd0);

      // level held 20 cycles: one strobe, one cycle later
      wlog.delete();
      id_in = 8'h06; val_in = 8'h5A; en = 1;
      tick();
      chk("hold_latency", 8'(wlog.size()), 8'd1);
      repeat (19) tick();
      en = 0;
      tick();
      chk("hold_one_strobe", 8'(wlog.size()), 8'd1);
      if (wlog.size() >= 1) begin
         chk("hold_id", wlog[0].id, 8'h06);
         chk("hold_val", wlog[0].val, 8'h5A);
      end

      // ALL_LED_OFF_H write
      wlog.delete(); busy_cnt = 0;
      id_in = 8'd73; val_in = 8'h08; en = 1;
      tick();
      en = 0;
      repeat (24) tick();
`ifdef PCA_ALL_LED_BROADCAST_EN
      chk("bcast_count", 8'(wlog.size()), 8'd17);
      chk("bcast_busy", 8'(busy_cnt), 8'd17);
      if (wlog.size() >= 17) begin
         chk("bcast_first", wlog[0].id, 8'd73);
         bad = 0;
         for (int k = 0; k < 16; k++)
            if (wlog[k + 1] != {8'(9 + 4 * k), 8'h08}) bad++;
         chk("bcast_channels", 8'(bad), 8'd0);
      end
`else
      chk("passthru_count", 8'(wlog.size()), 8'd1);
      chk("passthru_busy", 8'(busy_cnt), 8'd0);
`endif

      // soft reset part way through (ch=5 when broadcast is built)
      id_in = 8'd70; val_in = 8'h33; en = 1;
      tick();
      en = 0;
      repeat (5) tick();
      soft_n = 0;
      tick();
      soft_n = 1;
      chk("soft_no_write", 8'(write_enable_o), 8'd0);
      wlog.delete(); drops = 0;
      repeat (10) tick();
      id_in = 8'd2; val_in = 8'h77; en = 1;
      tick();
      en = 0;
      tick();
      id_in = 8'd3; val_in = 8'h55; en = 1;
      tick();
      en = 0;
      repeat (80) tick();
      chk("soft_count", 8'(wlog.size()), 8'd77);
      chk("soft_drops", 8'(drops), 8'd1);
      if (wlog.size() >= 77) begin
         chk("soft_restart_id", wlog[0].id, 8'd0);
         chk("soft_pend_id", wlog[76].id, 8'd2);
         chk("soft_pend_val", wlog[76].val, 8'h77);
      end

      // out-of-range id
      wlog.delete(); drops = 0;
      id_in = 8'h50; val_in = 8'hAB; en = 1;
      tick();
      chk("oor_drop", 8'(drop_o), 8'd1);
      en = 0;
      tick();
      chk("oor_drop_len", 8'(drop_o), 8'd0);
      repeat (3) tick();
      chk("oor_no_write", 8'(wlog.size()), 8'd0);
      chk("oor_drops", 8'(drops), 8'd1);

      // random traffic
      for (int c = 0; c < 4000; c++) begin
         rst_n  = ($urandom_range(0, 1999) != 0);
         soft_n = ($urandom_range(0, 249) != 0);
         en     = ($urandom_range(0, 2) == 0);
         r      = $urandom_range(0, 9);
         if (r < 3)
            id_in = 8'(70 + $urandom_range(0, 3));
         else if (r < 4)
            id_in = 8'($urandom_range(76, 255));
         else
            id_in = 8'($urandom_range(0, 75));
         val_in = 8'($urandom);
         tick();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/pca_register_write_sequencer.md
Name: pca_register_write_sequencer

Overview:
- Sole owner of the register-store write port. It sits between the I2C target's write strobe and the register store.
- Arbitrates three write sources into one write-per-cycle stream:
  - power-on / software-reset default sweep,
  - single I2C register writes,
  - ALL_LED broadcast expansion into the 16 per-channel LED registers.
- Reports busy and init status to the top level.

Parameters:
- NUM_REGS, 76: register-store entries, indexed 0..75 (store index, after high-register offset removal).
- ALL_LED_BASE, 70: store index of ALL_LED_ON_L. ALL_LED registers occupy 70..73.
- LED_BASE, 6: store index of LED0_ON_L. Channel k byte b is at LED_BASE + 4k + b.
- NUM_CH, 16: number of LED channels.

Ports:
- clk_i  input  1  system clock
- rst_ni  input  1  synchronous active-low reset
- i2c_register_id_i  input  8  store index from the I2C target
- i2c_register_value_i  input  8  write data from the I2C target
- i2c_write_enable_i  input  1  level write request; may stay high for many clk cycles
- soft_rst_ni  input  1  active-low software-reset pulse from the I2C target
- write_register_id_o  output  8  store index to write
- write_register_value_o  output  8  store write data
- write_enable_o  output  1  one-cycle store write strobe
- busy_o  output  1  high while sweeping or broadcasting
- init_done_o  output  1  high once the first reset sweep completes
- drop_o  output  1  one-cycle pulse when an I2C write is discarded

Behaviour:
- Reset (rst_ni low at a clk edge):
  - write_enable_o=0, write_register_id_o=0, write_register_value_o=0, drop_o=0, init_done_o=0, busy_o=0.
  - Pending buffer cleared; state=SWEEP with sweep index 0.
  - Sweep begins on the first clk edge with rst_ni high.
- States: IDLE, SWEEP, BCAST.
- All outputs are registered.
- Write acceptance:
  - A request is the rising edge of i2c_write_enable_i (registered previous value vs current).
  - Exactly one request per rising edge, however long the level is held.
- IDLE:
  - Request with id < NUM_REGS: the next cycle issues write_enable_o=1 with that id and value (1-cycle latency).
  - If id is in 70..73 and broadcast is compiled in, go to BCAST with ch=0.
  - Request with id >= NUM_REGS: no write; drop_o pulses.
- BCAST:
  - One write per cycle: id = LED_BASE + 4*ch + (saved_id - ALL_LED_BASE), value = saved value; ch increments.
  - After ch = NUM_CH-1, return to IDLE.
  - A broadcast is therefore 17 consecutive strobes with busy_o high from the first through the 17th.
- SWEEP:
  - One write per cycle for index 0..NUM_REGS-1 with default data:
    - 0 -> 0x11, 1 -> 0x04, 2 -> 0xE2, 3 -> 0xE4, 4 -> 0xE8, 5 -> 0xE0;
    - every LED_BASE + 4k + 3 -> 0x10, 73 -> 0x10, 74 -> 0x1E;
    - all others 0x00.
  - After index NUM_REGS-1, init_done_o is set (sticky until rst_ni) and the state returns to IDLE.
  - busy_o is high throughout.
- Pending buffer (one entry):
  - A request arriving in SWEEP or BCAST is held in the buffer.
  - It is serviced as an IDLE request on the cycle after the state returns to IDLE.
  - A request arriving while the buffer is full is discarded; drop_o pulses.
- soft_rst_ni low sampled in any state:
  - The current operation is aborted and the pending buffer cleared.
  - State becomes SWEEP with index 0; a sweep already in progress restarts from 0.
  - init_done_o keeps its value.
  - A request edge in the same cycle is discarded with a drop_o pulse.
- Priority: rst_ni > soft_rst_ni > pending buffer > new request.
- Every write_enable_o pulse is exactly one cycle. Two writes never merge.

Optional Feature:
- Macro: PCA_ALL_LED_BROADCAST_EN.
- Defined: ALL_LED writes (ids 70..73) trigger the 16-channel BCAST expansion.
- Undefined: the BCAST state is not built. ALL_LED writes are single pass-through writes, the same as any other id, and busy_o is driven only by SWEEP.

Test Plan:
- Release rst_ni -> 76 consecutive strobes, ids 0..75. Check id0=0x11, id9=0x10, id74=0x1E, id7=0x00. init_done_o rises the cycle after id 75; busy_o falls.
- After init, hold i2c_write_enable_i high 20 cycles with id 0x06, value 0x5A -> exactly one strobe (id 6, 0x5A), one cycle after the rising edge.
- With the macro defined, write id 73 value 0x08 -> strobes at id 73, then 9, 13, ..., 69 (16 channel writes), all 0x08; busy_o high for 17 cycles. With the macro undefined -> one strobe only.
- Pulse soft_rst_ni low mid-broadcast at ch=5 -> channel writes stop and a sweep restarts at id 0. A request issued during the sweep is written after it completes. A second request during the sweep gives a drop_o pulse.
- Write id 0x50 (>= NUM_REGS) in IDLE -> no strobe; drop_o pulses one cycle.
